// File: rtl/ws2812b_strip.sv
// WS2812B/SK6812 frame driver: streams PIX_NUM pixels of BPP bits, MSB first,
// from a 1-cycle-latency pixel RAM, then holds the latch low period.
module ws2812b_strip #(
  parameter int CNT_T0H = 11,
  parameter int CNT_T1H = 23,
  parameter int CNT_BIT = 34,
  parameter int CNT_RES = 2160,
  parameter int PIX_NUM = 8,
  parameter int ADDR_W  = 8,
  parameter int BPP     = 24
) (
  input  logic              Clock_27mhz,
  input  logic              rst,
  input  logic              start,
  input  logic [BPP-1:0]    pix_data,
  output logic              pix_rd,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              busy,
  output logic              done,
  output logic              WS2812B_IO,
  output logic [2:0]        state_dbg
);

  localparam int CW = $clog2(CNT_BIT);
  localparam int BW = $clog2(BPP);
  localparam int RW = $clog2(CNT_RES + 1);

  localparam logic [CW-1:0]     C_LAST = CW'(CNT_BIT - 1);
  localparam logic [CW-1:0]     C_T0H  = CW'(CNT_T0H);
  localparam logic [CW-1:0]     C_T1H  = CW'(CNT_T1H);
  localparam logic [BW-1:0]     B_LAST = BW'(BPP - 1);
  localparam logic [BW-1:0]     B_PRE  = BW'(BPP - 2);
  localparam logic [RW-1:0]     R_LAST = RW'(CNT_RES - 1);
  localparam logic [ADDR_W-1:0] P_LAST = ADDR_W'(PIX_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_BIT   = 3'd3,
    S_LATCH = 3'd4
  } state_t;

  state_t            state;
  logic [BPP-1:0]    shift_q;
  logic [BPP-1:0]    next_q;
  logic [CW-1:0]     cyc_q;
  logic [BW-1:0]     bit_q;
  logic [RW-1:0]     res_q;
  logic [ADDR_W-1:0] pix_idx;
  logic              rd_d1;
  logic [CW-1:0]     th;
  logic [CW-1:0]     cyc_inc;

  assign state_dbg = state;

  always_comb begin
    th      = shift_q[BPP-1] ? C_T1H : C_T0H;
    cyc_inc = cyc_q + CW'(1);
  end

  always_ff @(posedge Clock_27mhz or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      shift_q    <= '0;
      next_q     <= '0;
      cyc_q      <= '0;
      bit_q      <= '0;
      res_q      <= '0;
      pix_idx    <= '0;
      rd_d1      <= 1'b0;
      pix_rd     <= 1'b0;
      pix_addr   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      WS2812B_IO <= 1'b0;
    end else begin
      done   <= 1'b0;
      pix_rd <= 1'b0;
      rd_d1  <= pix_rd;
      case (state)
        S_IDLE: begin
          WS2812B_IO <= 1'b0;
          if (start) begin
            state    <= S_FETCH;
            busy     <= 1'b1;
            pix_rd   <= 1'b1;
            pix_addr <= '0;
            pix_idx  <= '0;
          end
        end
        S_FETCH: state <= S_WAIT;
        S_WAIT: begin
          shift_q    <= pix_data;
          bit_q      <= '0;
          cyc_q      <= '0;
          WS2812B_IO <= 1'b1;
          state      <= S_BIT;
        end
        S_BIT: begin
          // RAM output for the prefetched word is valid two edges after the strobe
          if (rd_d1) next_q <= pix_data;
          if (cyc_q == C_LAST) begin
            cyc_q <= '0;
            if (bit_q == B_LAST) begin
              if (pix_idx == P_LAST) begin
                state      <= S_LATCH;
                res_q      <= '0;
                WS2812B_IO <= 1'b0;
              end else begin
                shift_q    <= next_q;
                bit_q      <= '0;
                pix_idx    <= pix_idx + ADDR_W'(1);
                WS2812B_IO <= 1'b1;
              end
            end else begin
              shift_q    <= {shift_q[BPP-2:0], 1'b0};
              bit_q      <= bit_q + BW'(1);
              WS2812B_IO <= 1'b1;
              if (bit_q == B_PRE && pix_idx != P_LAST) begin
                pix_rd   <= 1'b1;
                pix_addr <= pix_idx + ADDR_W'(1);
              end
            end
          end else begin
            cyc_q      <= cyc_inc;
            WS2812B_IO <= (cyc_inc < th);
          end
        end
        S_LATCH: begin
          WS2812B_IO <= 1'b0;
          if (res_q == R_LAST) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            res_q <= res_q + RW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812b_strip.sv
// Bench for ws2812b_strip: a 3-pixel 24-bit strip with a background scoreboard
// monitor, and a 1-pixel 32-bit strip checked inline.
module tb_ws2812b_strip;

  localparam int T0H = 11;
  localparam int T1H = 23;
  localparam int CB  = 34;
  localparam int RES = 2160;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A: PIX_NUM=3, BPP=24
  logic        start_a = 1'b0;
  logic [23:0] pix_data_a = '0;
  logic        pix_rd_a, busy_a, done_a, io_a;
  logic [7:0]  pix_addr_a;
  logic [2:0]  state_a;
  logic [23:0] ram_a [0:3];

  ws2812b_strip #(.CNT_T0H(T0H), .CNT_T1H(T1H), .CNT_BIT(CB), .CNT_RES(RES),
                  .PIX_NUM(3), .ADDR_W(8), .BPP(24)) dut_a (
    .Clock_27mhz(clk), .rst(rst_n), .start(start_a), .pix_data(pix_data_a),
    .pix_rd(pix_rd_a), .pix_addr(pix_addr_a), .busy(busy_a), .done(done_a),
    .WS2812B_IO(io_a), .state_dbg(state_a));

  // RAM data is only guaranteed for one cycle after the latch; scramble otherwise
  always @(posedge clk) begin
    if (pix_rd_a) pix_data_a <= ram_a[pix_addr_a[1:0]];
    else          pix_data_a <= 24'($urandom());
  end

  // instance B: PIX_NUM=1, BPP=32
  logic        start_b = 1'b0;
  logic [31:0] pix_data_b = '0;
  logic        pix_rd_b, busy_b, done_b, io_b;
  logic [7:0]  pix_addr_b;
  logic [2:0]  state_b;

  ws2812b_strip #(.CNT_T0H(T0H), .CNT_T1H(T1H), .CNT_BIT(CB), .CNT_RES(RES),
                  .PIX_NUM(1), .ADDR_W(8), .BPP(32)) dut_b (
    .Clock_27mhz(clk), .rst(rst_n), .start(start_b), .pix_data(pix_data_b),
    .pix_rd(pix_rd_b), .pix_addr(pix_addr_b), .busy(busy_b), .done(done_b),
    .WS2812B_IO(io_b), .state_dbg(state_b));

  always @(posedge clk) begin
    if (pix_rd_b) pix_data_b <= 32'h0000_000F;
    else          pix_data_b <= $urandom();
  end

  // scoreboard queues for instance A
  logic [7:0]  exp_hi_q[$];
  logic [31:0] exp_rd_rel_q[$];
  logic [7:0]  exp_rd_addr_q[$];
  logic [31:0] exp_done_q[$];
  int e0_a = 0;
  int rd_cnt_a = 0;
  int done_cnt_a = 0;
  int last_rise_a = 0;
  bit have_rise_a = 0;
  logic io_prev_a = 1'b0;

  always @(negedge clk) begin
    logic [7:0]  e_hi;
    logic [31:0] e_rel;
    logic [7:0]  e_addr;
    if (!rst_n) begin
      have_rise_a = 0;
      io_prev_a   = 1'b0;
    end else begin
      if (io_a && !io_prev_a) begin
        if (have_rise_a) begin
          total++;
          if (cyc - last_rise_a !== CB) begin
            bad++;
            $display("FAIL cell_period: got %0d want %0d at cyc %0d", cyc - last_rise_a, CB, cyc);
          end
        end
        last_rise_a = cyc;
        have_rise_a = 1;
      end
      if (!io_a && io_prev_a) begin
        total++;
        if (exp_hi_q.size() == 0) begin
          bad++;
          $display("FAIL high_unexpected: got %0d cycles, none expected", cyc - last_rise_a);
        end else begin
          e_hi = exp_hi_q.pop_front();
          if (32'(cyc - last_rise_a) !== 32'(e_hi)) begin
            bad++;
            $display("FAIL high_time: got %0d want %0d at rel %0d", cyc - last_rise_a, e_hi, cyc - e0_a);
          end
        end
      end
      if (pix_rd_a) begin
        rd_cnt_a++;
        total++;
        if (exp_rd_rel_q.size() == 0) begin
          bad++;
          $display("FAIL pix_rd_unexpected: addr %0d at rel %0d", pix_addr_a, cyc - e0_a);
        end else begin
          e_rel  = exp_rd_rel_q.pop_front();
          e_addr = exp_rd_addr_q.pop_front();
          if (32'(cyc - e0_a) !== e_rel || pix_addr_a !== e_addr) begin
            bad++;
            $display("FAIL pix_rd: got addr %0d rel %0d want addr %0d rel %0d",
                     pix_addr_a, cyc - e0_a, e_addr, e_rel);
          end
        end
      end
      if (done_a) begin
        done_cnt_a++;
        total++;
        if (exp_done_q.size() == 0) begin
          bad++;
          $display("FAIL done_unexpected: at rel %0d", cyc - e0_a);
        end else begin
          e_rel = exp_done_q.pop_front();
          if (32'(cyc - e0_a) !== e_rel || busy_a !== 1'b0) begin
            bad++;
            $display("FAIL done_time: got rel %0d busy %b want rel %0d busy 0", cyc - e0_a, busy_a, e_rel);
          end
        end
        have_rise_a = 0;
        if (start_a) e0_a = cyc + 1;
      end
      io_prev_a = io_a;
    end
  end

  task automatic push_frame_a();
    for (int n = 0; n < 3; n++) begin
      for (int b = 23; b >= 0; b--) exp_hi_q.push_back(ram_a[n][b] ? 8'(T1H) : 8'(T0H));
      exp_rd_addr_q.push_back(8'(n));
      exp_rd_rel_q.push_back(n == 0 ? 32'd0 : 32'(2 + ((n - 1) * 24 + 23) * CB));
    end
    exp_done_q.push_back(32'(2 + 3 * 24 * CB + RES));
  endtask

  task automatic flush_a();
    exp_hi_q.delete();
    exp_rd_rel_q.delete();
    exp_rd_addr_q.delete();
    exp_done_q.delete();
  endtask

  task automatic start_frame_a();
    @(negedge clk);
    start_a = 1'b1;
    e0_a = cyc + 1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int n_done, input string tag);
    int d0 = done_cnt_a;
    for (int i = 0; i < 12000 && (done_cnt_a - d0) < n_done; i++) @(negedge clk);
    total++;
    if ((done_cnt_a - d0) < n_done) begin
      bad++;
      $display("FAIL %s_timeout: got %0d done pulses want %0d", tag, done_cnt_a - d0, n_done);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_drained(input string tag);
    total++;
    if (exp_hi_q.size() != 0 || exp_rd_rel_q.size() != 0 || exp_done_q.size() != 0 || busy_a !== 1'b0) begin
      bad++;
      $display("FAIL %s_drain: left hi=%0d rd=%0d done=%0d busy=%b want 0 0 0 0",
               tag, exp_hi_q.size(), exp_rd_rel_q.size(), exp_done_q.size(), busy_a);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({io_a, busy_a, done_a, pix_rd_a, pix_addr_a, state_a} !== 15'd0) begin
      bad++;
      $display("FAIL reset_a: got io=%b busy=%b done=%b rd=%b addr=%0d st=%0d want all 0",
               io_a, busy_a, done_a, pix_rd_a, pix_addr_a, state_a);
    end
    total++;
    if ({io_b, busy_b, done_b, pix_rd_b, pix_addr_b, state_b} !== 15'd0) begin
      bad++;
      $display("FAIL reset_b: got io=%b busy=%b done=%b rd=%b addr=%0d st=%0d want all 0",
               io_b, busy_b, done_b, pix_rd_b, pix_addr_b, state_b);
    end
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame();
    int r0 = rd_cnt_a;
    push_frame_a();
    start_frame_a();
    total++;
    if (busy_a !== 1'b1) begin
      bad++;
      $display("FAIL frame_busy: got %b want 1", busy_a);
    end
    wait_done_a(1, "frame");
    total++;
    if (rd_cnt_a - r0 !== 3) begin
      bad++;
      $display("FAIL frame_rd_count: got %0d want 3", rd_cnt_a - r0);
    end
    check_drained("frame");
  endtask

  task automatic test_ignore_start();
    int r0 = rd_cnt_a;
    int d0 = done_cnt_a;
    push_frame_a();
    start_frame_a();
    while (cyc < e0_a + 100) @(negedge clk);
    total++;
    if (busy_a !== 1'b1) begin
      bad++;
      $display("FAIL ignore_busy: got %b want 1", busy_a);
    end
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a(1, "ignore");
    repeat (50) @(negedge clk);
    total++;
    if (rd_cnt_a - r0 !== 3 || done_cnt_a - d0 !== 1) begin
      bad++;
      $display("FAIL ignore_counts: got rd=%0d done=%0d want rd=3 done=1", rd_cnt_a - r0, done_cnt_a - d0);
    end
    check_drained("ignore");
  endtask

  task automatic test_back_to_back();
    int r0 = rd_cnt_a;
    int d0 = done_cnt_a;
    bit seen = 0;
    push_frame_a();
    push_frame_a();
    @(negedge clk);
    start_a = 1'b1;
    e0_a = cyc + 1;
    for (int i = 0; i < 6000 && !seen; i++) begin
      @(negedge clk);
      if (done_a) seen = 1;
    end
    @(negedge clk);
    total++;
    if (!seen || pix_rd_a !== 1'b1 || pix_addr_a !== 8'd0) begin
      bad++;
      $display("FAIL b2b_restart: got done_seen=%0d rd=%b addr=%0d want 1 1 0", seen, pix_rd_a, pix_addr_a);
    end
    start_a = 1'b0;
    wait_done_a(1, "b2b");
    repeat (20) @(negedge clk);
    total++;
    if (rd_cnt_a - r0 !== 6 || done_cnt_a - d0 !== 2) begin
      bad++;
      $display("FAIL b2b_counts: got rd=%0d done=%0d want rd=6 done=2", rd_cnt_a - r0, done_cnt_a - d0);
    end
    check_drained("b2b");
  endtask

  task automatic test_reset_mid();
    int r0;
    push_frame_a();
    start_frame_a();
    while (cyc < e0_a + 500) @(negedge clk);
    total++;
    if (io_a !== 1'b1) begin
      bad++;
      $display("FAIL midrst_pre_high: got %b want 1", io_a);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({io_a, busy_a, pix_rd_a, pix_addr_a} !== 11'd0) begin
      bad++;
      $display("FAIL midrst_outputs: got io=%b busy=%b rd=%b addr=%0d want all 0", io_a, busy_a, pix_rd_a, pix_addr_a);
    end
    flush_a();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    r0 = rd_cnt_a;
    push_frame_a();
    start_frame_a();
    wait_done_a(1, "midrst");
    total++;
    if (rd_cnt_a - r0 !== 3) begin
      bad++;
      $display("FAIL midrst_rd_count: got %0d want 3", rd_cnt_a - r0);
    end
    check_drained("midrst");
  endtask

  task automatic test_bpp32();
    logic [7:0] exp_q[$];
    logic [7:0] e;
    int e0_b, rise, rd_cnt, done_rel;
    logic prev = 1'b0;
    bit fin = 0;
    for (int i = 0; i < 28; i++) exp_q.push_back(8'(T0H));
    for (int i = 0; i < 4; i++)  exp_q.push_back(8'(T1H));
    rise = 0;
    rd_cnt = 0;
    done_rel = -1;
    @(negedge clk);
    start_b = 1'b1;
    e0_b = cyc + 1;
    @(negedge clk);
    start_b = 1'b0;
    for (int i = 0; i < 4000 && !fin; i++) begin
      if (pix_rd_b) begin
        rd_cnt++;
        total++;
        if (pix_addr_b !== 8'd0) begin
          bad++;
          $display("FAIL bpp32_addr: got %0d want 0", pix_addr_b);
        end
      end
      if (io_b && !prev) rise = cyc;
      if (!io_b && prev) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL bpp32_extra_high: got %0d cycles", cyc - rise);
        end else begin
          e = exp_q.pop_front();
          if (32'(cyc - rise) !== 32'(e)) begin
            bad++;
            $display("FAIL bpp32_high_time: got %0d want %0d", cyc - rise, e);
          end
        end
      end
      if (done_b) begin
        done_rel = cyc - e0_b;
        fin = 1;
      end
      prev = io_b;
      @(negedge clk);
    end
    total++;
    if (done_rel !== 2 + 32 * CB + RES || rd_cnt !== 1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL bpp32_frame: got done_rel=%0d rd=%0d left=%0d want done_rel=%0d rd=1 left=0",
               done_rel, rd_cnt, exp_q.size(), 2 + 32 * CB + RES);
    end
  endtask

  initial begin
    ram_a[0] = 24'hAAAAAA;
    ram_a[1] = 24'h000001;
    ram_a[2] = 24'h800000;
    ram_a[3] = 24'h000000;
    test_reset();
    test_frame();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_bpp32();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ws2812b_strip.md
# ws2812b_strip

Frame-level WS2812B/SK6812 strip driver: the parametrised successor to the single-bit encoder. It streams PIX_NUM pixels of BPP bits each, MSB first, from a pixel memory with 1-cycle synchronous read latency, and produces gap-free bit cells on one output pin. After the last pixel it holds a latch/reset low period. It sits between the frame-buffer RAM and the LED pin, and is started by the animation controller one frame at a time.

## Interface
- CNT_T0H, 11: high-time cycles for a '0' bit (0.41 us at 27 MHz)
- CNT_T1H, 23: high-time cycles for a '1' bit (0.85 us)
- CNT_BIT, 34: total bit-cell cycles (1.26 us); must satisfy CNT_T1H < CNT_BIT, CNT_T0H ≥ 1, CNT_BIT ≥ 4
- CNT_RES, 2160: latch low cycles after the last bit (80 us)
- PIX_NUM, 8: pixels per frame, 1..2^ADDR_W
- ADDR_W, 8: pixel address width
- BPP, 24: bits per pixel; 24 (GRB) or 32 (GRBW)
- Clock_27mhz  in  1  system clock; all logic on the rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  frame request; sampled only in IDLE
- pix_data  in  BPP  pixel word from RAM; MSB is transmitted first
- pix_rd  out  1  one-cycle read strobe to RAM
- pix_addr  out  ADDR_W  pixel address, valid while pix_rd=1
- busy  out  1  frame in progress, including the latch period
- done  out  1  one-cycle pulse at frame end
- WS2812B_IO  out  1  registered LED data line

## Operation
- Reset (asynchronous, any state): state=IDLE; WS2812B_IO=0, busy=0, done=0, pix_rd=0, pix_addr=0. All counters and shift registers are cleared. A frame interrupted by reset is abandoned; the pin goes low immediately.
- States are IDLE, FETCH, WAIT, BIT, LATCH.
- IDLE: WS2812B_IO=0.
  - start=1 → FETCH; busy<=1, pix_rd<=1, pix_addr<=0.
- FETCH: pix_rd<=0 → WAIT. The RAM registers the address on this edge.
- WAIT: capture pix_data into the shift register; bit counter<=0, cycle counter<=0 → BIT.
- BIT: the cycle counter c runs 0..CNT_BIT-1.
  - WS2812B_IO=1 for c < Th, 0 otherwise. Th=CNT_T1H if the current bit is 1, else CNT_T0H.
  - At c=CNT_BIT-1 the shift register advances one bit.
- Prefetch: at c=0 of the last bit (index BPP-1) of pixel n < PIX_NUM-1, pulse pix_rd for one cycle with pix_addr=n+1. pix_data is captured into a next-word register 2 edges later. At the end of the last bit the shift register loads from next-word. There is no idle cycle between pixels.
- After the last bit of pixel PIX_NUM-1 → LATCH: WS2812B_IO=0 for CNT_RES cycles.
  - Then done<=1 for one cycle, busy<=0 → IDLE.
- start while busy=1 is ignored; no queuing.
- start held high continuously: the next frame begins on the edge after done (IDLE samples start).
- Pixel index and bit counters are sized for PIX_NUM and BPP. pix_addr never exceeds PIX_NUM-1.

## Timing
- E0 = the edge that samples start=1 in IDLE.
  - E0: pix_rd=1, pix_addr=0.
  - E1: RAM latches.
  - E2: data captured and WS2812B_IO rises (first bit).
- Bit cell: exactly CNT_BIT cycles. High for exactly CNT_T0H or CNT_T1H cycles, then low for the remainder.
- Pixel n occupies edges E2+n·BPP·CNT_BIT to E2+(n+1)·BPP·CNT_BIT.
- Prefetch pix_rd for pixel n+1 at edge E2+(n·BPP+BPP-1)·CNT_BIT.
- done=1 and busy=0 from edge E0+2+PIX_NUM·BPP·CNT_BIT+CNT_RES.
- pix_rd is asserted exactly PIX_NUM times per frame.
- RAM contract: pix_data must reflect pix_addr from the edge after pix_rd=1, and remain stable until the following edge.

## Test plan
- PIX_NUM=1, BPP=24, data 0xFF0000:
  - Eight 23-cycle highs, then sixteen 11-cycle highs, each cell 34 cycles.
  - Then 2160 low cycles; done at E0+2+816+2160.
- PIX_NUM=3, RAM {0xAAAAAA, 0x000001, 0x800000}:
  - pix_addr pulses 0, 1, 2 at E0, E2+23·34, E2+47·34.
  - Pixel boundaries show no gap (continuous 34-cycle cells).
  - The LSB of pixel 1 and the MSB of pixel 2 both give 23-cycle highs.
- start pulsed again at E0+100 (busy=1) → ignored:
  - Exactly one done and 3 pix_rd pulses.
- start held high: second frame's pix_rd at the edge after done; total 2 done pulses over 2 frame periods.
- rst low at E0+500 (mid-bit high) → WS2812B_IO, busy, and pix_rd low immediately.
  - After release, start restarts at pix_addr=0 with a full frame.
- BPP=32, PIX_NUM=1, data 0x0000000F:
  - 28 cells with 11-cycle highs, then 4 with 23-cycle highs.
  - done at E0+2+1088+2160.
